// File: rtl/btn_pkg.sv
// Shared definitions for the push-button debouncer.
// Holds the FSM state encoding, the clock-rate constants and a counter width helper.
package btn_pkg;

  // Bit 1 of the encoding equals the debounced level, so level = state[1].
  typedef enum logic [1:0] {
    S_LOW    = 2'b00,
    S_CHK_HI = 2'b01,
    S_HIGH   = 2'b11,
    S_CHK_LO = 2'b10
  } db_state_t;

  localparam int CLK_HZ        = 100000000;
  localparam int DB_CYCLES_SIM = 16;
  // 10 ms stability window at CLK_HZ.
  localparam int DB_CYCLES_HW  = CLK_HZ / 100;

  // Width of a counter that must hold the values 0..n-1 (at least one bit).
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/btn_debounce_db_cell.sv
// Single-bit debouncer: 2-FF synchroniser, 4-state stability FSM and counter.
// Produces a registered clean level plus one-cycle rise/fall pulses.
module db_cell
  import btn_pkg::*;
#(
  parameter int DB_CYCLES = DB_CYCLES_HW
) (
  input  logic clk_100mhz,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam int CW = cnt_w(DB_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

  logic [1:0]    sync_reg;
  logic          raw_s;
  db_state_t     state_reg, state_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic          level_reg, rise_reg, fall_reg;

  assign raw_s = sync_reg[1];

  // Two-stage synchroniser for the asynchronous button input.
  always_ff @(posedge clk_100mhz or posedge rst) begin
    if (rst) sync_reg <= 2'b00;
    else     sync_reg <= {sync_reg[0], raw};
  end

  // State and stability counter registers.
  always_ff @(posedge clk_100mhz or posedge rst) begin
    if (rst) begin
      state_reg <= S_LOW;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // Next-state logic; the counter stops at CNT_LAST because the state
  // always changes there, so it can never wrap.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      S_LOW: begin
        if (raw_s) begin
          state_next = S_CHK_HI;
          cnt_next   = '0;
        end
      end
      S_CHK_HI: begin
        if (!raw_s) begin
          state_next = S_LOW;
          cnt_next   = '0;
        end else if (cnt_reg == CNT_LAST) begin
          state_next = S_HIGH;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      S_HIGH: begin
        if (!raw_s) begin
          state_next = S_CHK_LO;
          cnt_next   = '0;
        end
      end
      S_CHK_LO: begin
        if (raw_s) begin
          state_next = S_HIGH;
          cnt_next   = '0;
        end else if (cnt_reg == CNT_LAST) begin
          state_next = S_LOW;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      default: begin
        state_next = S_LOW;
        cnt_next   = '0;
      end
    endcase
  end

  // Registered outputs that update on the same edge the FSM settles high/low.
  always_ff @(posedge clk_100mhz or posedge rst) begin
    if (rst) begin
      level_reg <= 1'b0;
      rise_reg  <= 1'b0;
      fall_reg  <= 1'b0;
    end else begin
      level_reg <= state_next[1];
      rise_reg  <= (state_reg == S_CHK_HI) && (state_next == S_HIGH);
      fall_reg  <= (state_reg == S_CHK_LO) && (state_next == S_LOW);
    end
  end

  assign level = level_reg;
  assign rise  = rise_reg;
  assign fall  = fall_reg;

endmodule

// File: rtl/btn_debounce.sv
// Debounces N_BTN raw push buttons and derives the manual single-step clock.
// Optional auto-repeat on the step button is enabled by defining BTN_AUTOREPEAT_EN.
module btn_debounce
  import btn_pkg::*;
#(
  parameter int N_BTN     = 4,
  parameter int DB_CYCLES = DB_CYCLES_HW,
  parameter int STEP_BTN  = 0
`ifdef BTN_AUTOREPEAT_EN
  ,
  parameter int RPT_DELAY  = 50000000,
  parameter int RPT_PERIOD = 10000000
`endif
) (
  input  logic             clk_100mhz,
  input  logic             rst,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_rise,
  output logic [N_BTN-1:0] btn_fall,
  output logic             step_clk
);

  logic [N_BTN-1:0] cell_level, cell_rise, cell_fall;
  logic             step_clk_reg;

  genvar gi;
  generate
    for (gi = 0; gi < N_BTN; gi++) begin : g_cell
      db_cell #(.DB_CYCLES(DB_CYCLES)) u_cell (
        .clk_100mhz (clk_100mhz),
        .rst        (rst),
        .raw        (btn_raw[gi]),
        .level      (cell_level[gi]),
        .rise       (cell_rise[gi]),
        .fall       (cell_fall[gi])
      );
    end
  endgenerate

  assign btn_level = cell_level;
  assign btn_fall  = cell_fall;

`ifdef BTN_AUTOREPEAT_EN
  localparam int HW = cnt_w(RPT_DELAY);
  localparam int PW = cnt_w(RPT_PERIOD);
  localparam logic [HW-1:0] HOLD_LAST = HW'(RPT_DELAY - 1);
  localparam logic [PW-1:0] PER_LAST  = PW'(RPT_PERIOD - 1);
  localparam logic [PW-1:0] PER_HALF  = PW'(RPT_PERIOD / 2);

  logic [HW-1:0] hold_cnt_reg;
  logic [PW-1:0] per_cnt_reg;
  logic          rpt_on_reg;
  logic          rep_rise_reg;

  // Hold timer, then a free-running period counter; step_clk is low for the
  // first half of each period and high for the second, and every new high
  // phase raises an extra rise pulse. Release clears everything next cycle.
  always_ff @(posedge clk_100mhz or posedge rst) begin
    if (rst) begin
      hold_cnt_reg <= '0;
      per_cnt_reg  <= '0;
      rpt_on_reg   <= 1'b0;
      rep_rise_reg <= 1'b0;
      step_clk_reg <= 1'b0;
    end else if (!cell_level[STEP_BTN]) begin
      hold_cnt_reg <= '0;
      per_cnt_reg  <= '0;
      rpt_on_reg   <= 1'b0;
      rep_rise_reg <= 1'b0;
      step_clk_reg <= 1'b0;
    end else if (!rpt_on_reg) begin
      step_clk_reg <= 1'b1;
      rep_rise_reg <= 1'b0;
      if (hold_cnt_reg == HOLD_LAST) begin
        rpt_on_reg  <= 1'b1;
        per_cnt_reg <= '0;
      end else begin
        hold_cnt_reg <= hold_cnt_reg + 1'b1;
      end
    end else begin
      per_cnt_reg  <= (per_cnt_reg == PER_LAST) ? '0 : per_cnt_reg + 1'b1;
      step_clk_reg <= (per_cnt_reg >= PER_HALF);
      rep_rise_reg <= (per_cnt_reg == PER_HALF);
    end
  end

  assign btn_rise = cell_rise | (N_BTN'(rep_rise_reg) << STEP_BTN);
`else
  // Step clock is the clean step-button level delayed by one register.
  always_ff @(posedge clk_100mhz or posedge rst) begin
    if (rst) step_clk_reg <= 1'b0;
    else     step_clk_reg <= cell_level[STEP_BTN];
  end

  assign btn_rise = cell_rise;
`endif

  assign step_clk = step_clk_reg;

endmodule

// File: tb/tb_btn_debounce.sv
// Self-checking bench for btn_debounce (default build, DB_CYCLES = 16).
// A run-length reference model predicts every output; directed scenarios add
// absolute timing checks derived from the debounce latency.
module tb_btn_debounce;
  import btn_pkg::*;

  localparam int N  = 4;
  localparam int DB = DB_CYCLES_SIM;

  logic         clk_100mhz = 1'b0;
  logic         rst        = 1'b1;
  logic [N-1:0] btn_raw    = '0;
  logic [N-1:0] btn_level, btn_rise, btn_fall;
  logic         step_clk;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk_100mhz = ~clk_100mhz;

  btn_debounce #(
    .N_BTN     (N),
    .DB_CYCLES (DB),
    .STEP_BTN  (0)
  ) dut (
    .clk_100mhz (clk_100mhz),
    .rst        (rst),
    .btn_raw    (btn_raw),
    .btn_level  (btn_level),
    .btn_rise   (btn_rise),
    .btn_fall   (btn_fall),
    .step_clk   (step_clk)
  );

  // Reference model: after two sync stages, a bit's level flips once the
  // synchronised input has disagreed with it for DB+1 consecutive samples.
  logic [N-1:0] m_s1, m_s2, m_lvl, m_rise, m_fall;
  logic         m_step;
  int           m_run [N];

  always @(posedge clk_100mhz or posedge rst) begin
    if (rst) begin
      m_s1   <= '0;
      m_s2   <= '0;
      m_lvl  <= '0;
      m_rise <= '0;
      m_fall <= '0;
      m_step <= 1'b0;
      for (int i = 0; i < N; i++) m_run[i] <= 0;
    end else begin
      m_s1   <= btn_raw;
      m_s2   <= m_s1;
      m_step <= m_lvl[0];
      for (int i = 0; i < N; i++) begin
        if (m_s2[i] != m_lvl[i]) begin
          if (m_run[i] == DB) begin
            m_lvl[i]  <= ~m_lvl[i];
            m_rise[i] <= ~m_lvl[i];
            m_fall[i] <= m_lvl[i];
            m_run[i]  <= 0;
          end else begin
            m_run[i]  <= m_run[i] + 1;
            m_rise[i] <= 1'b0;
            m_fall[i] <= 1'b0;
          end
        end else begin
          m_run[i]  <= 0;
          m_rise[i] <= 1'b0;
          m_fall[i] <= 1'b0;
        end
      end
    end
  end

  task automatic test_reset();
    rst     = 1'b1;
    btn_raw = '0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk_100mhz);
      n_cmp++;
      if ({btn_level, btn_rise, btn_fall, step_clk} !== 13'b0) begin
        n_bad++;
        $display("FAIL reset_hold cyc=%0d got lvl=%b rise=%b fall=%b step=%b exp all 0",
                 c, btn_level, btn_rise, btn_fall, step_clk);
      end
    end
    rst = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk_100mhz);
      n_cmp++;
      if ({btn_level, btn_rise, btn_fall, step_clk} !== 13'b0) begin
        n_bad++;
        $display("FAIL reset_idle cyc=%0d got lvl=%b rise=%b fall=%b step=%b exp all 0",
                 c, btn_level, btn_rise, btn_fall, step_clk);
      end
    end
    $display("test_reset: done");
  endtask

  task automatic test_clean_rise();
    logic el, er, es;
    for (int c = 0; c <= 30; c++) begin
      @(negedge clk_100mhz);
      el = (c >= DB + 3);
      er = (c == DB + 3);
      es = (c >= DB + 4);
      n_cmp++;
      if (btn_level[0] !== el || btn_rise[0] !== er || step_clk !== es ||
          {btn_level, btn_rise, btn_fall, step_clk} !== {m_lvl, m_rise, m_fall, m_step}) begin
        n_bad++;
        $display("FAIL clean_rise cyc=%0d got lvl0=%b rise0=%b step=%b all=%b exp lvl0=%b rise0=%b step=%b all=%b",
                 c, btn_level[0], btn_rise[0], step_clk,
                 {btn_level, btn_rise, btn_fall, step_clk}, el, er, es,
                 {m_lvl, m_rise, m_fall, m_step});
      end
      if (c == 0) btn_raw[0] = 1'b1;
    end
    for (int c = 0; c <= 25; c++) begin
      @(negedge clk_100mhz);
      el = (c < DB + 3);
      er = (c == DB + 3);
      n_cmp++;
      if (btn_level[0] !== el || btn_fall[0] !== er ||
          {btn_level, btn_rise, btn_fall, step_clk} !== {m_lvl, m_rise, m_fall, m_step}) begin
        n_bad++;
        $display("FAIL clean_fall cyc=%0d got lvl0=%b fall0=%b exp lvl0=%b fall0=%b",
                 c, btn_level[0], btn_fall[0], el, er);
      end
      if (c == 0) btn_raw[0] = 1'b0;
    end
    $display("test_clean_rise: done");
  endtask

  task automatic test_bounce();
    logic el, er;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk_100mhz);
      el = (c >= 60 + DB + 3);
      er = (c == 60 + DB + 3);
      n_cmp++;
      if (btn_level[1] !== el || btn_rise[1] !== er || btn_fall[1] !== 1'b0 ||
          {btn_level, btn_rise, btn_fall, step_clk} !== {m_lvl, m_rise, m_fall, m_step}) begin
        n_bad++;
        $display("FAIL bounce cyc=%0d got lvl1=%b rise1=%b fall1=%b exp lvl1=%b rise1=%b fall1=0",
                 c, btn_level[1], btn_rise[1], btn_fall[1], el, er);
      end
      btn_raw[1] = (c < 60) ? (((c / 5) % 2) == 0) : 1'b1;
    end
    btn_raw[1] = 1'b0;
    for (int c = 0; c < 25; c++) begin
      @(negedge clk_100mhz);
      n_cmp++;
      if ({btn_level, btn_rise, btn_fall, step_clk} !== {m_lvl, m_rise, m_fall, m_step}) begin
        n_bad++;
        $display("FAIL bounce_release cyc=%0d got %b exp %b", c,
                 {btn_level, btn_rise, btn_fall, step_clk}, {m_lvl, m_rise, m_fall, m_step});
      end
    end
    $display("test_bounce: done");
  endtask

  task automatic test_glitch();
    for (int c = 0; c < 45; c++) begin
      @(negedge clk_100mhz);
      n_cmp++;
      if (btn_level[2] !== 1'b0 || btn_rise[2] !== 1'b0 || btn_fall[2] !== 1'b0 ||
          {btn_level, btn_rise, btn_fall, step_clk} !== {m_lvl, m_rise, m_fall, m_step}) begin
        n_bad++;
        $display("FAIL glitch cyc=%0d got lvl2=%b rise2=%b fall2=%b exp 0 0 0",
                 c, btn_level[2], btn_rise[2], btn_fall[2]);
      end
      btn_raw[2] = (c < 15);
    end
    $display("test_glitch: done");
  endtask

  task automatic test_simultaneous();
    logic [N-1:0] el, ep;
    for (int c = 0; c <= 25; c++) begin
      @(negedge clk_100mhz);
      el = (c >= DB + 3) ? '1 : '0;
      ep = (c == DB + 3) ? '1 : '0;
      n_cmp++;
      if (btn_level !== el || btn_rise !== ep || btn_fall !== '0) begin
        n_bad++;
        $display("FAIL simul_press cyc=%0d got lvl=%b rise=%b fall=%b exp lvl=%b rise=%b fall=0000",
                 c, btn_level, btn_rise, btn_fall, el, ep);
      end
      if (c == 0) btn_raw = '1;
    end
    for (int c = 0; c <= 25; c++) begin
      @(negedge clk_100mhz);
      el = (c >= DB + 3) ? '0 : '1;
      ep = (c == DB + 3) ? '1 : '0;
      n_cmp++;
      if (btn_level !== el || btn_fall !== ep || btn_rise !== '0) begin
        n_bad++;
        $display("FAIL simul_release cyc=%0d got lvl=%b rise=%b fall=%b exp lvl=%b rise=0000 fall=%b",
                 c, btn_level, btn_rise, btn_fall, el, ep);
      end
      if (c == 0) btn_raw = '0;
    end
    $display("test_simultaneous: done");
  endtask

  task automatic test_reset_mid();
    logic el, er;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk_100mhz);
      n_cmp++;
      if (btn_level[3] !== 1'b0 ||
          {btn_level, btn_rise, btn_fall, step_clk} !== {m_lvl, m_rise, m_fall, m_step}) begin
        n_bad++;
        $display("FAIL reset_mid_count cyc=%0d got lvl3=%b all=%b exp lvl3=0 all=%b",
                 c, btn_level[3], {btn_level, btn_rise, btn_fall, step_clk},
                 {m_lvl, m_rise, m_fall, m_step});
      end
      if (c == 0)  btn_raw[3] = 1'b1;
      if (c == 12) rst = 1'b1;
    end
    rst = 1'b0;
    for (int c = 1; c <= 25; c++) begin
      @(negedge clk_100mhz);
      el = (c >= DB + 3);
      er = (c == DB + 3);
      n_cmp++;
      if (btn_level[3] !== el || btn_rise[3] !== er) begin
        n_bad++;
        $display("FAIL reset_restart cyc=%0d got lvl3=%b rise3=%b exp lvl3=%b rise3=%b",
                 c, btn_level[3], btn_rise[3], el, er);
      end
    end
    btn_raw[3] = 1'b0;
    for (int c = 0; c < 25; c++) @(negedge clk_100mhz);
    n_cmp++;
    if (btn_level !== '0) begin
      n_bad++;
      $display("FAIL reset_cleanup got lvl=%b exp 0000", btn_level);
    end
    $display("test_reset_mid: done");
  endtask

  task automatic test_random();
    int hold [N];
    for (int i = 0; i < N; i++) hold[i] = 1;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk_100mhz);
      n_cmp++;
      if ({btn_level, btn_rise, btn_fall, step_clk} !== {m_lvl, m_rise, m_fall, m_step}) begin
        n_bad++;
        $display("FAIL random cyc=%0d got lvl=%b rise=%b fall=%b step=%b exp lvl=%b rise=%b fall=%b step=%b",
                 c, btn_level, btn_rise, btn_fall, step_clk, m_lvl, m_rise, m_fall, m_step);
      end
      for (int i = 0; i < N; i++) begin
        hold[i]--;
        if (hold[i] <= 0) begin
          btn_raw[i] = ~btn_raw[i];
          hold[i]    = int'($urandom_range(40, 1));
        end
      end
    end
    $display("test_random: done");
  endtask

  initial begin
    test_reset();
    test_clean_rise();
    test_bounce();
    test_glitch();
    test_simultaneous();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
